// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state codes, default divider
// and a bounded-width parity helper.
package uart_pkg;

  localparam int unsigned DEFAULT_CLK_DIV = 5208;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  // XOR of the low n bits of d; bits at or above n do not contribute.
  function automatic logic parity_n(input logic [7:0] d, input int n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < n) p = p ^ d[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_frame_if.sv
// Byte handshake and serial-line bundle between a byte producer and the UART
// transmitter.
interface uart_tx_frame_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx_bps.sv
// Bit-period counter for the transmitter; bit_end_o marks the last cycle of
// each bit rather than the bit centre used on the receive side.
module uart_tx_bps
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_end_o = en_i && (cnt_q == LAST);

  // Wrapping at bit_end is what clears the count on each state entry.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = bit_end_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one byte per valid/ready handshake, serialised as
// start, LSB-first data, optional parity and stop bits on a registered line.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic clk,
  input  logic rst_n,
  uart_tx_frame_if.slave bus
);

  localparam logic [2:0] LAST_IDX  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       stop_idx_q, stop_idx_d;
  logic       par_q, par_d;
  logic       tx_q, tx_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       bit_end;
  logic       accept;

  assign accept = bus.tx_valid && ready_q;

  uart_tx_bps #(.CLK_DIV(CLK_DIV)) u_bps (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (state_q != ST_IDLE),
    .clr_i     (state_q == ST_IDLE),
    .bit_end_o (bit_end)
  );

  // tx_d always carries the line level of the bit being entered, so the
  // registered output lines up with the state change.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    par_d      = par_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        tx_d    = 1'b1;
        if (accept) begin
          state_d    = ST_START;
          shift_d    = bus.tx_data;
          par_d      = parity_n(bus.tx_data, int'(DATA_BITS)) ^ (PARITY_ODD != 0);
          idx_d      = 3'd0;
          stop_idx_d = 1'b0;
          tx_d       = 1'b0;
          ready_d    = 1'b0;
          busy_d     = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d = idx_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_idx_q == LAST_STOP) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.tx_ready = ready_q;
  assign bus.tx_busy  = busy_q;
  assign bus.tx_done  = done_q;

endmodule
